multimode_shift_register: RTL

//   Parametrised universal shift/rotate register, successor to the 8-bit shifter with parallel load.

---
 rtl/multimode_shift_register.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/multimode_shift_register.sv
// Universal shift/rotate register with parallel load, serial-out and a
// multi-cycle "shift by N" sequencer driven by a Start/Busy/Done handshake.
module multimode_shift_register #(
  parameter int BUSWIDTH = 8,
  parameter int CNT_W    = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                En_i,
  input  logic [2:0]          S_i,
  input  logic [BUSWIDTH-1:0] data_i,
  input  logic                data_L,
  input  logic                data_R,
  input  logic [CNT_W-1:0]    Cnt_i,
  input  logic                Start_i,
  output logic [BUSWIDTH-1:0] Y_o,
  output logic                SerOut_o,
  output logic                Busy_o,
  output logic                Done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  state_t              state_reg;
  logic [BUSWIDTH-1:0] y_reg;
  logic                ser_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [2:0]          mode_reg;

  logic [2:0]          step_mode;
  logic [BUSWIDTH-1:0] step_y;
  logic                step_ser;
  logic                start_ok;

  // In RUN the latched mode drives the datapath; S_i is ignored there.
  assign step_mode = (state_reg == RUN) ? mode_reg : S_i;

  assign start_ok = (S_i == M_SHR) || (S_i == M_SHL) || (S_i == M_ROR) ||
                    (S_i == M_ROL) || (S_i == M_ASR);

  always_comb begin
    step_y   = y_reg;
    step_ser = ser_reg;
    case (step_mode)
      M_SHR: begin
        step_y   = {data_R, y_reg[BUSWIDTH-1:1]};
        step_ser = y_reg[0];
      end
      M_SHL: begin
        step_y   = {y_reg[BUSWIDTH-2:0], data_L};
        step_ser = y_reg[BUSWIDTH-1];
      end
      M_LOAD: begin
        step_y = data_i;
      end
      M_ROR: begin
        step_y   = {y_reg[0], y_reg[BUSWIDTH-1:1]};
        step_ser = y_reg[0];
      end
      M_ROL: begin
        step_y   = {y_reg[BUSWIDTH-2:0], y_reg[BUSWIDTH-1]};
        step_ser = y_reg[BUSWIDTH-1];
      end
      M_ASR: begin
        step_y   = {y_reg[BUSWIDTH-1], y_reg[BUSWIDTH-1:1]};
        step_ser = y_reg[0];
      end
      default: begin
        step_y   = y_reg;
        step_ser = ser_reg;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      ser_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= '0;
      mode_reg  <= M_HOLD;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start_i && start_ok) begin
            // Accept edge only latches the request; data moves on later edges.
            mode_reg  <= S_i;
            count_reg <= Cnt_i;
            if (Cnt_i != '0) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end else if (En_i) begin
            y_reg   <= step_y;
            ser_reg <= step_ser;
          end
        end
        RUN: begin
          if (En_i) begin
            y_reg     <= step_y;
            ser_reg   <= step_ser;
            count_reg <= count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Y_o      = y_reg;
  assign SerOut_o = ser_reg;
  assign Busy_o   = busy_reg;
  assign Done_o   = done_reg;

endmodule
